key_debounce: RTL

//   Conditions one raw active-low pushbutton (KEY[n]) into clean events for the counter/state stage.

---
 rtl/key_debounce.sv | 117 +++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and edge-detect one active-low pushbutton.
// Define KEY_AUTO_REPEAT_EN to add hold-to-repeat o_press pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 24,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic key_s;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic rpt_hit;
  // Synchroniser resets to released so a key held through reset is seen as a fresh press
  assign key_s = ~sync_q[1];
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_key};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  // A bounce takes priority over the counter reaching its final value
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) state_d = IDLE;
        else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else press_d = rpt_hit;
      end
      RELEASE_WAIT: begin
        if (key_s) state_d = PRESSED;
        else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic rpt_armed_q, rpt_armed_d;
  assign rpt_hit = (state_q == PRESSED) && key_s && (rpt_cnt_q == (rpt_armed_q ? RP_LAST : RD_LAST));
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
  // Held-time freezes across a release bounce and clears once the key is back to idle
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    if (state_q == IDLE || state_q == PRESS_WAIT) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end else if (state_q == PRESSED && key_s) begin
      rpt_cnt_d   = rpt_hit ? '0 : rpt_cnt_q + 1'b1;
      rpt_armed_d = rpt_armed_q | rpt_hit;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif
  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
endmodule
